// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus between the IF stage and the instruction memory.
//   imem_req   : fetch request valid (master -> slave)
//   imem_addr  : word-aligned fetch address (master -> slave)
//   imem_rdata : instruction word, meaningful only in a transfer cycle (slave -> master)
//   imem_ready : memory completes the request this cycle (slave -> master)
// A transfer happens in any cycle where imem_req and imem_ready are both 1.
interface if_fetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: PC register, variable-latency instruction fetch handshake and the
// IF/ID pipeline register. Loads npc from the next-PC selector, honours
// stalls (pc_write=0) and EX redirects (flush).
//
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   npc              : next PC from the next-PC selector
//   pc_write         : 1 = decode accepts / PC may advance, 0 = stall
//   flush            : redirect from EX, npc holds the target this cycle
//   pc               : current fetch PC, fed back to the next-PC selector
//   imem             : fetch bus (master side)
//   if_id_valid/pc/instr : IF/ID pipeline register
//
// Optional feature macro: FETCH_SKID_EN
//   defined   -> an instruction returned during a stall is kept in a skid
//                register (HOLD state) and handed to decode on release.
//   undefined -> such an instruction is dropped and re-requested.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [31:0]           npc,
  input  logic                  pc_write,
  input  logic                  flush,
  output logic [31:0]           pc,
  if_fetch_stage_if.master      imem,
  output logic                  if_id_valid,
  output logic [31:0]           if_id_pc,
  output logic [31:0]           if_id_instr
);

  localparam int unsigned XLEN = 32;

`ifdef FETCH_SKID_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;
`endif

  state_t          state, state_nx;
  logic [XLEN-1:0] req_addr, req_addr_nx;
  logic [XLEN-1:0] pc_nx;
  logic            valid_nx;
  logic [XLEN-1:0] id_pc_nx;
  logic [XLEN-1:0] id_instr_nx;
`ifdef FETCH_SKID_EN
  logic [XLEN-1:0] skid, skid_nx;
`endif

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; imem_req is 1 in FETCH/DRAIN, so imem_ready alone marks a transfer there
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = FETCH;
      FETCH: begin
        if (imem.imem_ready) begin
`ifdef FETCH_SKID_EN
          if (!flush && !pc_write) state_nx = HOLD;
`endif
        end else if (flush) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: if (imem.imem_ready) state_nx = FETCH;
`ifdef FETCH_SKID_EN
      HOLD:  if (flush || pc_write) state_nx = FETCH;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs and next values for PC, request address and IF/ID
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    pc_nx          = pc;
    req_addr_nx    = req_addr;
    valid_nx       = if_id_valid;
    id_pc_nx       = if_id_pc;
    id_instr_nx    = if_id_instr;
`ifdef FETCH_SKID_EN
    skid_nx        = skid;
`endif
    case (state)
      IDLE: req_addr_nx = pc;
      FETCH: begin
        imem.imem_req = 1'b1;
        // Track the address in flight so a mid-request redirect can keep it stable
        req_addr_nx   = pc;
        if (imem.imem_ready) begin
          if (flush) begin
            valid_nx = 1'b0;
            pc_nx    = npc;
          end else if (pc_write) begin
            valid_nx    = 1'b1;
            id_pc_nx    = pc;
            id_instr_nx = imem.imem_rdata;
            pc_nx       = npc;
          end
`ifdef FETCH_SKID_EN
          else begin
            skid_nx = imem.imem_rdata;
          end
`endif
        end else if (flush) begin
          valid_nx = 1'b0;
          pc_nx    = npc;
        end else if (pc_write) begin
          // Memory wait with decode ready: hand decode a bubble
          valid_nx = 1'b0;
        end
      end
      DRAIN: begin
        // Finish the stale request at its original address; its data is dropped
        imem.imem_req  = 1'b1;
        imem.imem_addr = req_addr;
        valid_nx       = 1'b0;
        if (flush) pc_nx = npc;
      end
`ifdef FETCH_SKID_EN
      HOLD: begin
        if (flush) begin
          valid_nx = 1'b0;
          pc_nx    = npc;
        end else if (pc_write) begin
          valid_nx    = 1'b1;
          id_pc_nx    = pc;
          id_instr_nx = skid;
          pc_nx       = npc;
        end
      end
`endif
      default: ;
    endcase
  end

  // PC, request address and IF/ID registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else begin
      pc          <= pc_nx;
      req_addr    <= req_addr_nx;
      if_id_valid <= valid_nx;
      if_id_pc    <= id_pc_nx;
      if_id_instr <= id_instr_nx;
    end
  end

`ifdef FETCH_SKID_EN
  // Skid register for an instruction returned while decode is stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) skid <= NOP_INSTR;
    else       skid <= skid_nx;
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage. The memory returns
// {16'hC0DE, addr[15:0]} for every address; npc is pc+4 unless a redirect
// target is being driven. Inputs change and outputs are sampled on negedges.
module tb_if_fetch_stage;

  logic        clk;
  logic        rstn;
  logic [31:0] npc;
  logic        pc_write;
  logic        flush;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  logic        ready;
  logic        use_tgt;
  logic [31:0] tgt;

  int n_tests;
  int n_fail;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage dut (
    .clk         (clk),
    .rstn        (rstn),
    .npc         (npc),
    .pc_write    (pc_write),
    .flush       (flush),
    .pc          (pc),
    .imem        (imem_bus),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr)
  );

  assign imem_bus.imem_rdata = {16'hC0DE, imem_bus.imem_addr[15:0]};
  assign imem_bus.imem_ready = ready;
  assign npc = use_tgt ? tgt : pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic test_reset;
    rstn = 1'b0; ready = 1'b1; pc_write = 1'b1; flush = 1'b0; use_tgt = 1'b0; tgt = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    n_tests++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_bus.imem_req); end
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
    n_tests++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc got %h exp 0", if_id_pc); end
    n_tests++; if (if_id_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr got %h exp 00000013", if_id_instr); end
    rstn = 1'b1;
    #1;
    n_tests++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b exp 0", imem_bus.imem_req); end
    @(negedge clk);
    n_tests++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req got %b exp 1", imem_bus.imem_req); end
    n_tests++; if (imem_bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr got %h exp 0", imem_bus.imem_addr); end
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid got %b exp 0", if_id_valid); end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      e = 32'(4 * i);
      @(negedge clk);
      n_tests++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %b exp 1", i, if_id_valid); end
      n_tests++; if (if_id_pc !== e) begin n_fail++; $display("FAIL seq_pc[%0d] got %h exp %h", i, if_id_pc, e); end
      n_tests++; if (if_id_instr !== mem_word(e)) begin n_fail++; $display("FAIL seq_instr[%0d] got %h exp %h", i, if_id_instr, mem_word(e)); end
    end
    n_tests++; if (imem_bus.imem_addr !== 32'hC) begin n_fail++; $display("FAIL seq_addr got %h exp 0000000c", imem_bus.imem_addr); end
  endtask

  task automatic test_mem_wait;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (imem_bus.imem_addr !== 32'hC) begin n_fail++; $display("FAIL wait_addr[%0d] got %h exp 0000000c", i, imem_bus.imem_addr); end
      n_tests++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req[%0d] got %b exp 1", i, imem_bus.imem_req); end
      n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid[%0d] got %b exp 0", i, if_id_valid); end
    end
    ready = 1'b1;
    @(negedge clk);
    n_tests++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL wait_done_valid got %b exp 1", if_id_valid); end
    n_tests++; if (if_id_pc !== 32'hC) begin n_fail++; $display("FAIL wait_done_pc got %h exp 0000000c", if_id_pc); end
    n_tests++; if (if_id_instr !== mem_word(32'hC)) begin n_fail++; $display("FAIL wait_done_instr got %h exp %h", if_id_instr, mem_word(32'hC)); end
    n_tests++; if (imem_bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL wait_next_addr got %h exp 00000010", imem_bus.imem_addr); end
  endtask

  task automatic test_flush_drain;
    ready = 1'b0;
    @(negedge clk);
    flush = 1'b1; use_tgt = 1'b1; tgt = 32'h100;
    n_tests++; if (imem_bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL drain_pre_addr got %h exp 00000010", imem_bus.imem_addr); end
    @(negedge clk);
    flush = 1'b0; use_tgt = 1'b0;
    n_tests++; if (imem_bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL drain_addr0 got %h exp 00000010", imem_bus.imem_addr); end
    n_tests++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL drain_req got %b exp 1", imem_bus.imem_req); end
    n_tests++; if (pc !== 32'h100) begin n_fail++; $display("FAIL drain_pc got %h exp 00000100", pc); end
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid0 got %b exp 0", if_id_valid); end
    @(negedge clk);
    n_tests++; if (imem_bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL drain_addr1 got %h exp 00000010", imem_bus.imem_addr); end
    ready = 1'b1;
    @(negedge clk);
    n_tests++; if (imem_bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL redirect_addr got %h exp 00000100", imem_bus.imem_addr); end
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_discard_valid got %b exp 0", if_id_valid); end
    @(negedge clk);
    n_tests++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_valid got %b exp 1", if_id_valid); end
    n_tests++; if (if_id_pc !== 32'h100) begin n_fail++; $display("FAIL redirect_pc got %h exp 00000100", if_id_pc); end
    n_tests++; if (if_id_instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL redirect_instr got %h exp %h", if_id_instr, mem_word(32'h100)); end
  endtask

  task automatic test_flush_beats_stall;
    flush = 1'b1; pc_write = 1'b0; use_tgt = 1'b1; tgt = 32'h200;
    @(negedge clk);
    flush = 1'b0; pc_write = 1'b1; use_tgt = 1'b0;
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL fstall_valid got %b exp 0", if_id_valid); end
    n_tests++; if (pc !== 32'h200) begin n_fail++; $display("FAIL fstall_pc got %h exp 00000200", pc); end
    n_tests++; if (imem_bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL fstall_addr got %h exp 00000200", imem_bus.imem_addr); end
    @(negedge clk);
    n_tests++; if (if_id_pc !== 32'h200 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL fstall_next got pc %h v %b exp pc 00000200 v 1", if_id_pc, if_id_valid); end
  endtask

  task automatic test_stall;
    flush = 1'b1; use_tgt = 1'b1; tgt = 32'h20;
    @(negedge clk);
    flush = 1'b0; use_tgt = 1'b0; pc_write = 1'b0;
    n_tests++; if (imem_bus.imem_addr !== 32'h20) begin n_fail++; $display("FAIL stall_addr got %h exp 00000020", imem_bus.imem_addr); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
`ifdef FETCH_SKID_EN
      n_tests++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d] got %b exp 0", i, imem_bus.imem_req); end
`else
      n_tests++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h20) begin n_fail++; $display("FAIL rereq[%0d] got req %b addr %h exp req 1 addr 00000020", i, imem_bus.imem_req, imem_bus.imem_addr); end
`endif
      n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid[%0d] got %b exp 0", i, if_id_valid); end
      n_tests++; if (pc !== 32'h20) begin n_fail++; $display("FAIL stall_pc[%0d] got %h exp 00000020", i, pc); end
    end
    pc_write = 1'b1;
    @(negedge clk);
    n_tests++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL release_valid got %b exp 1", if_id_valid); end
    n_tests++; if (if_id_pc !== 32'h20) begin n_fail++; $display("FAIL release_pc got %h exp 00000020", if_id_pc); end
    n_tests++; if (if_id_instr !== mem_word(32'h20)) begin n_fail++; $display("FAIL release_instr got %h exp %h", if_id_instr, mem_word(32'h20)); end
    n_tests++; if (imem_bus.imem_addr !== 32'h24 || imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL release_next got req %b addr %h exp req 1 addr 00000024", imem_bus.imem_req, imem_bus.imem_addr); end
  endtask

  task automatic test_reset_mid_request;
    ready = 1'b0;
    @(negedge clk);
    n_tests++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL pre_rst_req got %b exp 1", imem_bus.imem_req); end
    #2 rstn = 1'b0;
    #1;
    n_tests++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", imem_bus.imem_req); end
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", pc); end
    n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", if_id_valid); end
    n_tests++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL rst_id_pc got %h exp 0", if_id_pc); end
    n_tests++; if (if_id_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_instr got %h exp 00000013", if_id_instr); end
    ready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_tests++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rel_req got %b exp 0", imem_bus.imem_req); end
    @(negedge clk);
    n_tests++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rel_first got req %b addr %h exp req 1 addr 0", imem_bus.imem_req, imem_bus.imem_addr); end
    @(negedge clk);
    n_tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0) begin n_fail++; $display("FAIL rel_idid got v %b pc %h exp v 1 pc 0", if_id_valid, if_id_pc); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_sequential();
    test_mem_wait();
    test_flush_drain();
    test_flush_beats_stall();
    test_stall();
    test_reset_mid_request();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
